mag_window_stats: RTL
=====================

MAG_WINDOW_STATS -- requirements
Module: mag_window_stats

Interface
REQ-001 SHALL have parameter WIN_LOG2, default 3, log2 of samples per window (legal 1..6).
REQ-002 SHALL have parameter THRESH_HI, default 8'd180, alarm set level on window average.
REQ-003 SHALL have parameter THRESH_LO, default 8'd120, alarm clear level; THRESH_LO < THRESH_HI.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port ena  input  1  global enable; low freezes all state.
REQ-007 SHALL have port mag_in  input  8  unsigned magnitude sample from the sqrt(x^2+y^2) stage.
REQ-008 SHALL have port mag_valid  input  1  mag_in carries a new sample this cycle.
REQ-009 SHALL have port clear  input  1  synchronous restart of the current window.
REQ-010 SHALL have port win_max  output  8  maximum sample of last completed window.
REQ-011 SHALL have port win_min  output  8  minimum sample of last completed window.
REQ-012 SHALL have port win_avg  output  8  truncated mean of last completed window.
REQ-013 SHALL have port stats_valid  output  1  one-cycle pulse when win_* update.
REQ-014 SHALL have port alarm  output  1  hysteretic threshold flag on win_avg.
REQ-015 SHALL have port win_cnt  output  WIN_LOG2  samples accepted so far in open window.

Function
REQ-016 Sample SHALL be accepted on a rising edge where ena=1 and mag_valid=1; no other condition.
REQ-017 Open-window state SHALL be: sample counter (WIN_LOG2 bits), sum accumulator (8+WIN_LOG2 bits, no overflow possible), running max, running min.
REQ-018 First accepted sample of a window SHALL load run_max=run_min=mag_in and sum=mag_in.
REQ-019 Subsequent samples SHALL add to sum, update run_max if greater, run_min if smaller; ties leave value unchanged.
REQ-020 Accepting sample number 2^WIN_LOG2 SHALL, on that same edge, load win_max/win_min from final running values including that sample, win_avg = (sum incl. sample) >> WIN_LOG2, and assert stats_valid.
REQ-021 stats_valid SHALL be high exactly one cycle per completed window; latency from last sample edge to visible outputs is one clock (registered).
REQ-022 Counter SHALL wrap to 0 on window completion; a sample in the next cycle SHALL be first of new window (no dead cycle).
REQ-023 alarm SHALL update only on the stats_valid edge: set if new win_avg >= THRESH_HI, clear if new win_avg <= THRESH_LO, else hold.
REQ-024 clear=1 with ena=1 SHALL discard the open window (counter 0); win_*, alarm unchanged; stats_valid 0.
REQ-025 clear and accepted sample same edge: sample SHALL become first sample of the new window (win_cnt=1).
REQ-026 ena=0 SHALL hold all state and force stats_valid low; mag_valid and clear ignored.
REQ-027 win_cnt SHALL equal number of samples accepted in open window (0..2^WIN_LOG2-1).
REQ-028 win_max, win_min, win_avg, alarm SHALL hold between window completions.

Reset
REQ-029 rst_n low SHALL immediately (no clock) force win_max, win_min, win_avg, stats_valid, alarm, win_cnt and all internal state to 0.
REQ-030 Reset asserted mid-window SHALL discard partial window; first accepted sample after release starts a new window.

Verification
REQ-031 Default params, 8 samples 10,20,30,40,50,60,70,80 -> one stats_valid pulse after 8th; max=80, min=10, avg=45, alarm=0.
REQ-032 Window of 8x200 then window of 8x150 then 8x100 -> alarm 1, stays 1 (150 in band), clears to 0 at third window.
REQ-033 Back-to-back mag_valid for 16 cycles, values 0..15 -> two pulses 8 cycles apart; avg=3 then avg=11 (truncation).
REQ-034 3 samples of 255, clear, then 8 samples of 5 -> single pulse, max=min=avg=5; clear+valid same edge gives win_cnt=1.
REQ-035 mag_valid held high with ena toggling 1/0 -> only ena=1 edges counted; win_cnt frozen and stats_valid 0 while ena=0.
REQ-036 rst_n pulsed low after 5 samples, asynchronously mid-cycle -> outputs 0 immediately; next window needs full 8 samples.

Source files
------------

// File: rtl/mag_window_stats.sv
`default_nettype none
// ============================================================================
//  Module   : mag_window_stats
//  Purpose  : Windowed statistics on a stream of unsigned 8-bit magnitudes.
//             Collects 2^WIN_LOG2 accepted samples per window. At the end of
//             each window it publishes the max, min and truncated mean. It
//             also keeps a hysteretic alarm flag based on the mean.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   1         rising-edge clock
//    rst_n       in   1         asynchronous active-low reset
//    ena         in   1         global enable; low freezes all state
//    mag_in      in   8         unsigned magnitude sample
//    mag_valid   in   1         mag_in carries a new sample this cycle
//    clear       in   1         discard the open window (synchronous)
//    win_max     out  8         max of last completed window
//    win_min     out  8         min of last completed window
//    win_avg     out  8         truncated mean of last completed window
//    stats_valid out  1         one-cycle pulse when win_* update
//    alarm       out  1         hysteretic threshold flag on win_avg
//    win_cnt     out  WIN_LOG2  samples accepted in the open window
// ============================================================================
module mag_window_stats #(
    parameter int         WIN_LOG2  = 3,
    parameter logic [7:0] THRESH_HI = 8'd180,
    parameter logic [7:0] THRESH_LO = 8'd120
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [7:0]          mag_in,
    input  logic                mag_valid,
    input  logic                clear,
    output logic [7:0]          win_max,
    output logic [7:0]          win_min,
    output logic [7:0]          win_avg,
    output logic                stats_valid,
    output logic                alarm,
    output logic [WIN_LOG2-1:0] win_cnt
);

    localparam int                SUM_W    = 8 + WIN_LOG2;
    localparam logic [WIN_LOG2-1:0] LAST_IDX = {WIN_LOG2{1'b1}};

    // Open-window state
    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [7:0]          run_max_q, run_max_d;
    logic [7:0]          run_min_q, run_min_d;

    // Published results
    logic [7:0]          win_max_q, win_max_d;
    logic [7:0]          win_min_q, win_min_d;
    logic [7:0]          win_avg_q, win_avg_d;
    logic                stats_valid_q, stats_valid_d;
    logic                alarm_q, alarm_d;

    // Helper values for the sample being accepted this cycle
    logic [WIN_LOG2-1:0] cnt_base;
    logic                first_smp;
    logic [SUM_W-1:0]    sum_acc;
    logic [7:0]          max_acc;
    logic [7:0]          min_acc;
    logic [7:0]          avg_new;

    always_comb begin
        // A same-edge clear makes the incoming sample the first of a fresh window.
        cnt_base  = clear ? '0 : cnt_q;
        first_smp = (cnt_base == '0);
        sum_acc   = first_smp ? {{WIN_LOG2{1'b0}}, mag_in}
                              : sum_q + {{WIN_LOG2{1'b0}}, mag_in};
        max_acc   = (first_smp || (mag_in > run_max_q)) ? mag_in : run_max_q;
        min_acc   = (first_smp || (mag_in < run_min_q)) ? mag_in : run_min_q;
        // The sum cannot overflow, so the upper 8 bits are the truncated mean.
        avg_new   = sum_acc[SUM_W-1:WIN_LOG2];

        cnt_d         = cnt_q;
        sum_d         = sum_q;
        run_max_d     = run_max_q;
        run_min_d     = run_min_q;
        win_max_d     = win_max_q;
        win_min_d     = win_min_q;
        win_avg_d     = win_avg_q;
        alarm_d       = alarm_q;
        stats_valid_d = 1'b0;

        if (ena) begin
            if (mag_valid) begin
                if (cnt_base == LAST_IDX) begin
                    // Window completes on this edge and includes this sample.
                    cnt_d         = '0;
                    sum_d         = '0;
                    run_max_d     = 8'd0;
                    run_min_d     = 8'd0;
                    win_max_d     = max_acc;
                    win_min_d     = min_acc;
                    win_avg_d     = avg_new;
                    stats_valid_d = 1'b1;
                    if (avg_new >= THRESH_HI) begin
                        alarm_d = 1'b1;
                    end else if (avg_new <= THRESH_LO) begin
                        alarm_d = 1'b0;
                    end
                end else begin
                    cnt_d     = cnt_base + WIN_LOG2'(1);
                    sum_d     = sum_acc;
                    run_max_d = max_acc;
                    run_min_d = min_acc;
                end
            end else if (clear) begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            sum_q         <= '0;
            run_max_q     <= 8'd0;
            run_min_q     <= 8'd0;
            win_max_q     <= 8'd0;
            win_min_q     <= 8'd0;
            win_avg_q     <= 8'd0;
            stats_valid_q <= 1'b0;
            alarm_q       <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            sum_q         <= sum_d;
            run_max_q     <= run_max_d;
            run_min_q     <= run_min_d;
            win_max_q     <= win_max_d;
            win_min_q     <= win_min_d;
            win_avg_q     <= win_avg_d;
            stats_valid_q <= stats_valid_d;
            alarm_q       <= alarm_d;
        end
    end

    assign win_max     = win_max_q;
    assign win_min     = win_min_q;
    assign win_avg     = win_avg_q;
    assign stats_valid = stats_valid_q;
    assign alarm       = alarm_q;
    assign win_cnt     = cnt_q;

endmodule
`default_nettype wire
